seq_prio_enc: RTL and testbench
===============================

SEQ_PRIO_ENC -- requirements
Module: seq_prio_enc

Interface
REQ-001 Parameter: PRIO_HIGH, default 1, 1 = highest set bit index emitted first, 0 = lowest set bit index emitted first.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: load  input  1  capture request word w; honoured only while busy=0.
REQ-005 Port: w  input  8  multi-hot request word; bit i set means index i is requested.
REQ-006 Port: ready  input  1  consumer accepts y in the current cycle when valid=1.
REQ-007 Port: valid  output  1  y holds a valid encoded index.
REQ-008 Port: y  output  3  binary index of the current pending bit.
REQ-009 Port: last  output  1  the current y is the final pending index of this word.
REQ-010 Port: busy  output  1  the block is in EMIT state; new loads are ignored.
REQ-011 Port: zero  output  1  one-cycle pulse when load was accepted with w==0.

Function
REQ-012 The block SHALL implement two states, IDLE and EMIT, with busy=1 exactly when the state is EMIT.
REQ-013 In IDLE, load=1 with w!=0 SHALL register pending<=w and enter EMIT on the same edge.
REQ-014 In IDLE, load=1 with w==0 SHALL leave the state in IDLE, leave valid at 0, and assert zero for exactly the following cycle.
REQ-015 Latency SHALL be one cycle: load accepted at edge n gives valid=1 with the first index after edge n.
REQ-016 In EMIT, valid SHALL be 1, and y SHALL be the highest set index of pending (PRIO_HIGH=1) or the lowest set index (PRIO_HIGH=0).
REQ-017 last SHALL be 1 in EMIT exactly when pending has a single bit set; otherwise last SHALL be 0.
REQ-018 Handshake: on an edge with valid=1 and ready=1, the bit at index y SHALL be cleared in pending.
REQ-019 If last=1 on a handshake edge, the state SHALL return to IDLE, so that valid=0 and busy=0 in the next cycle.
REQ-020 While valid=1 and ready=0, y, last and pending SHALL hold stable with no change.
REQ-021 With ready held high, throughput SHALL be one index per cycle: a word with k bits set produces k consecutive valid cycles.
REQ-022 load SHALL be ignored whenever busy=1, including on the final-handshake edge; a new word is accepted no earlier than the first IDLE cycle.
REQ-023 When valid=0, y SHALL be 3'b000 and last SHALL be 0.
REQ-024 A ready input while valid=0 SHALL have no effect.

Reset
REQ-025 On a rising edge with rst_n=0, state SHALL become IDLE and pending 8'h00.
REQ-026 On that same edge, valid, y, last, busy and zero SHALL all become 0.
REQ-027 Reset SHALL take priority over load and the handshake, and a reset during EMIT SHALL discard all remaining pending indices.
REQ-028 Outputs SHALL follow rst_n only at clock edges, with no asynchronous path.

Verification
REQ-029 Hold rst_n=0 for 2 cycles with load=1 and w=8'hFF -> valid=busy=zero=last=0 and y=0 throughout; after release with load=0, the block stays IDLE.
REQ-030 PRIO_HIGH=1, load w=8'b1010_0100 with ready=1 -> y=7, 5, 2 on three consecutive valid cycles, last=1 only with y=2, then busy=0.
REQ-031 Load w=8'h81 with ready=0 for 3 cycles -> y=7, valid=1 and last=0 held for 3 cycles; then ready=1 gives y=7 followed by y=0 with last=1.
REQ-032 Load w=8'h00 -> zero=1 for one cycle; valid and busy stay 0.
REQ-033 Load w=8'hFF with ready=1, and assert load with w=8'h01 during emission -> y=7..0 over 8 cycles, the second load is ignored, and last=1 only with y=0.
REQ-034 Reset mid-emission after 2 of 4 indices, then PRIO_HIGH=0 with w=8'b0001_0110 -> the aborted word never resumes; the new word yields y=1, 2, 4.

Source files
------------

// File: rtl/seq_prio_enc.sv
// Sequential priority encoder: captures a multi-hot word and emits the index
// of each set bit, one per accepted handshake, highest-first or lowest-first.
module seq_prio_enc #(
  parameter int PRIO_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] w,
  input  logic       ready,
  output logic       valid,
  output logic [2:0] y,
  output logic       last,
  output logic       busy,
  output logic       zero
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic       zero_q, zero_d;

  logic [2:0] y_enc;
  logic       single_bit;
  logic       emitting;

  // Priority-encode the pending word; the later loop hit wins, so the loop
  // direction selects highest-first or lowest-first.
  always_comb begin
    y_enc = 3'd0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (pending_q[i]) y_enc = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending_q[i]) y_enc = 3'(i);
      end
    end
  end

  // Exactly one bit left means the current index is the final one.
  always_comb begin
    single_bit = (pending_q != 8'd0) &&
                 ((pending_q & (pending_q - 8'd1)) == 8'd0);
  end

  // Outputs are decoded from registered state only, so they move on clock edges.
  always_comb begin
    emitting = (state_q == EMIT);
    valid    = emitting;
    busy     = emitting;
    y        = emitting ? y_enc : 3'd0;
    last     = emitting && single_bit;
    zero     = zero_q;
  end

  // Next-state: capture in IDLE, clear the emitted bit on each handshake.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (w != 8'd0) begin
            pending_d = w;
            state_d   = EMIT;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      EMIT: begin
        // load is deliberately not examined here, even on the final edge.
        if (ready) begin
          pending_d = pending_q & ~(8'd1 << y_enc);
          if (single_bit) state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 8'd0;
      end
    endcase
  end

  // State register with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 8'd0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_prio_enc.sv
// Bench for seq_prio_enc: two instances (highest-first and lowest-first),
// expected indices queued at load time and compared as the DUTs emit.
module tb_seq_prio_enc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load  [2];
  logic [7:0] w     [2];
  logic       ready [2];
  logic       valid [2];
  logic [2:0] y     [2];
  logic       last  [2];
  logic       busy  [2];
  logic       zero  [2];

  int checks = 0;
  int errors = 0;

  // Entry: {dut id, last, y}
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  seq_prio_enc #(.PRIO_HIGH(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .load(load[0]), .w(w[0]), .ready(ready[0]),
    .valid(valid[0]), .y(y[0]), .last(last[0]), .busy(busy[0]), .zero(zero[0])
  );

  seq_prio_enc #(.PRIO_HIGH(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .load(load[1]), .w(w[1]), .ready(ready[1]),
    .valid(valid[1]), .y(y[1]), .last(last[1]), .busy(busy[1]), .zero(zero[1])
  );

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: expand a word into its emission order.
  task automatic push_exp(input int d, input logic [7:0] wv);
    int n;
    int total;
    int idx;
    logic [4:0] e;
    n = 0;
    total = $countones(wv);
    for (int k = 0; k < 8; k++) begin
      idx = (d == 0) ? 7 - k : k;
      if (wv[idx]) begin
        n++;
        e = {d[0], (n == total), 3'(idx)};
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: every valid cycle must match the queue head; pop on handshake.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        check_val("busy_eq_valid", busy[d], valid[d]);
        if (!valid[d]) begin
          check_val("idle_y", y[d], 0);
          check_val("idle_last", last[d], 0);
        end else if (exp_q.size() == 0) begin
          check_val("unexpected_valid", valid[d], 0);
        end else begin
          e = exp_q[0];
          check_val("dut_id", d, e[4]);
          check_val("y", y[d], e[2:0]);
          check_val("last", last[d], e[3]);
          if (ready[d]) begin
            void'(exp_q.pop_front());
            $display("emit dut=%0d y=%0d last=%0d", d, y[d], last[d]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one load for one edge; expected indices are queued as it is driven.
  task automatic do_load(input int d, input logic [7:0] wv);
    load[d] = 1'b1;
    w[d]    = wv;
    if (wv != 8'd0) push_exp(d, wv);
    $display("load dut=%0d w=%02h", d, wv);
    step();
    load[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input string tag);
    int n;
    n = 0;
    while (busy[d] && n < 40) begin
      step();
      n++;
    end
    check_val(tag, busy[d], 0);
    check_val({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      load[d] = 1'b1; w[d] = 8'hFF; ready[d] = 1'b1;
    end

    // Reset held two edges with load active.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_val("rst_valid", valid[d], 0);
        check_val("rst_busy", busy[d], 0);
        check_val("rst_zero", zero[d], 0);
        check_val("rst_last", last[d], 0);
        check_val("rst_y", y[d], 0);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    load[0] = 1'b0; load[1] = 1'b0;
    repeat (3) step();
    check_val("post_rst_idle", busy[0], 0);

    // Highest-first, three bits, ready high.
    do_load(0, 8'b1010_0100);
    check_val("latency_valid", valid[0], 1);
    wait_idle(0, "a4_idle");

    // Back-pressure: outputs hold while ready is low.
    ready[0] = 1'b0;
    do_load(0, 8'h81);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val("hold_valid", valid[0], 1);
      check_val("hold_y", y[0], 7);
      check_val("hold_last", last[0], 0);
      step();
    end
    ready[0] = 1'b1;
    wait_idle(0, "81_idle");

    // Zero word: one-cycle pulse, no emission.
    do_load(0, 8'h00);
    @(negedge clk);
    check_val("zero_pulse", zero[0], 1);
    check_val("zero_busy", busy[0], 0);
    step();
    @(negedge clk);
    check_val("zero_clear", zero[0], 0);
    step();

    // Full word with a competing load held through the final handshake.
    do_load(0, 8'hFF);
    load[0] = 1'b1;
    w[0]    = 8'h01;
    begin
      int n;
      n = 0;
      while (busy[0] && n < 40) begin
        step();
        n++;
      end
    end
    load[0] = 1'b0;
    check_val("ff_idle", busy[0], 0);
    check_val("ff_drained", exp_q.size(), 0);
    step();
    check_val("ignored_load", busy[0], 0);

    // Reset mid-emission after two of four indices.
    do_load(0, 8'h5A);
    step();
    step();
    rst_n = 1'b0;
    exp_q.delete();
    step();
    @(negedge clk);
    check_val("abort_busy", busy[0], 0);
    check_val("abort_valid", valid[0], 0);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    check_val("no_resume", busy[0], 0);

    // Lowest-first instance.
    do_load(1, 8'b0001_0110);
    wait_idle(1, "lo16_idle");
    do_load(1, 8'h80);
    check_val("single_last", last[1], 1);
    wait_idle(1, "lo80_idle");

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
